// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: FSM encoding, key codes
// and the row/column-to-key map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  localparam logic [2:0] COL_FIRST = 3'b110;

  // Layout: r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = *,0,#
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = 4'd3 * {2'b00, row} + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  function automatic logic [1:0] next_col(input logic [1:0] col);
    return (col >= 2'd2) ? 2'd0 : col + 2'd1;
  endfunction

  function automatic logic [2:0] col_pattern(input logic [1:0] col);
    return ~(3'b001 << col);
  endfunction

  function automatic logic [3:0] row_onehot(input logic [1:0] row);
    return 4'b0001 << row;
  endfunction

  // Only meaningful when exactly one bit of low is set.
  function automatic logic [1:0] row_index(input logic [3:0] low);
    logic [1:0] idx;
    casez (low)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic [9:0] digit_onehot(input logic [3:0] code);
    return (code < 4'd10) ? (10'd1 << code) : 10'd0;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; reset loads the
// idle level so no spurious activity appears after reset.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: rotates column strobes, debounces a single pressed key
// and emits one fixed-length registered command per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = 4,
  parameter int DEBOUNCE  = 3,
  parameter int PULSE_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_sense,
  output logic [2:0] col_drive,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       clearn,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DIV_W   = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int DEB_W   = (DEBOUNCE  > 1) ? $clog2(DEBOUNCE)  : 1;
  localparam int PULSE_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(PULSE_LEN - 1);

  logic [3:0] row_sync;

  state_t             state_reg;
  logic [1:0]         col_reg;
  logic [1:0]         row_reg;
  logic [DIV_W-1:0]   div_cnt_reg;
  logic [DEB_W-1:0]   deb_cnt_reg;
  logic [PULSE_W-1:0] pulse_cnt_reg;
  logic [2:0]         col_drive_reg;
  logic [9:0]         keypad_reg;
  logic               startn_reg;
  logic               clearn_reg;
  logic               key_valid_reg;
  logic [3:0]         key_code_reg;

  logic [3:0] row_low;
  logic       sample_tick;
  logic       one_low;
  logic       row_match;
  logic       rows_idle;
  logic [1:0] col_next;
  logic       emit_go;
  logic [3:0] emit_code;
  logic       pulse_done;

  sync_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_sense),
    .q   (row_sync)
  );

  always_comb begin
    row_low     = ~row_sync;
    sample_tick = (div_cnt_reg == DIV_LAST);
    one_low     = $onehot(row_low);
    row_match   = (row_low == row_onehot(row_reg));
    rows_idle   = (row_low == 4'h0);
    col_next    = next_col(col_reg);
    emit_go     = 1'b0;
    emit_code   = key_map(row_reg, col_reg);
    if (sample_tick) begin
      // With a single-sample debounce the first clean sample is already final.
      if (state_reg == ST_SCAN && one_low && DEBOUNCE == 1) begin
        emit_go   = 1'b1;
        emit_code = key_map(row_index(row_low), col_reg);
      end
      if (state_reg == ST_DEBOUNCE && row_match && deb_cnt_reg == DEB_LAST) begin
        emit_go = 1'b1;
      end
    end
    pulse_done = (state_reg == ST_EMIT) && (pulse_cnt_reg == PULSE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_SCAN;
      col_reg       <= 2'd0;
      row_reg       <= 2'd0;
      div_cnt_reg   <= '0;
      deb_cnt_reg   <= '0;
      pulse_cnt_reg <= '0;
      col_drive_reg <= COL_FIRST;
      keypad_reg    <= '0;
      startn_reg    <= 1'b1;
      clearn_reg    <= 1'b1;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
    end else begin
      div_cnt_reg <= sample_tick ? '0 : div_cnt_reg + 1'b1;

      case (state_reg)
        ST_SCAN: begin
          if (sample_tick) begin
            if (one_low) begin
              row_reg <= row_index(row_low);
              if (emit_go) begin
                state_reg     <= ST_EMIT;
                pulse_cnt_reg <= '0;
              end else begin
                state_reg   <= ST_DEBOUNCE;
                deb_cnt_reg <= DEB_W'(1);
              end
            end else begin
              col_reg       <= col_next;
              col_drive_reg <= col_pattern(col_next);
            end
          end
        end

        ST_DEBOUNCE: begin
          if (sample_tick) begin
            if (!row_match) begin
              state_reg     <= ST_SCAN;
              deb_cnt_reg   <= '0;
              col_reg       <= col_next;
              col_drive_reg <= col_pattern(col_next);
            end else if (emit_go) begin
              state_reg     <= ST_EMIT;
              deb_cnt_reg   <= '0;
              pulse_cnt_reg <= '0;
            end else begin
              deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
          end
        end

        ST_EMIT: begin
          // Pulse length is fixed; the key state is not looked at here.
          if (pulse_done) begin
            state_reg   <= ST_RELEASE;
            deb_cnt_reg <= '0;
            div_cnt_reg <= '0;
          end else begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (sample_tick) begin
            if (!rows_idle) begin
              deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
              state_reg     <= ST_SCAN;
              deb_cnt_reg   <= '0;
              col_reg       <= col_next;
              col_drive_reg <= col_pattern(col_next);
            end else begin
              deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
          end
        end

        default: state_reg <= ST_SCAN;
      endcase

      if (emit_go) begin
        keypad_reg    <= digit_onehot(emit_code);
        startn_reg    <= (emit_code != KEY_HASH);
        clearn_reg    <= (emit_code != KEY_STAR);
        key_valid_reg <= 1'b1;
        key_code_reg  <= emit_code;
      end else if (pulse_done) begin
        keypad_reg    <= '0;
        startn_reg    <= 1'b1;
        clearn_reg    <= 1'b1;
        key_valid_reg <= 1'b0;
      end
    end
  end

  assign col_drive = col_drive_reg;
  assign keypad    = keypad_reg;
  assign startn    = startn_reg;
  assign clearn    = clearn_reg;
  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;

endmodule
